mem_port_arbiter: RTL and testbench

Sequencing arbiter sharing the single-ported unified memory between the CPU's instruction-fetch requester and its load/store requester. It sits between the multi-cycle core and `Mem`. It accepts one request at a time over valid/ready handshakes, drives the memory port for exactly one access cycle, and returns a one-cycle response pulse with read data or an alignment error. Successive requests may be issued back-to-back at one transaction per two cycles.

---
 rtl/mem_port_arbiter_if.sv | 58 +++++
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Purpose : bundles the request/response handshakes of the fetch and
//           load/store requesters, the unified memory port, and the
//           arbiter's busy flag.
// Modports: slave  - the arbiter (accepts requests, drives memory port)
//           master - the core/memory side (issues requests, returns rdata)
// Signals : if_req_*/if_resp_*  fetch request and response
//           d_req_*/d_resp_*    load/store request and response
//           mem_*               single-ported memory access
//           busy                arbiter is in ACCESS or RESP
interface mem_port_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             if_req_valid;
  logic             if_req_ready;
  logic [WIDTH-1:0] if_req_addr;
  logic             if_resp_valid;
  logic [WIDTH-1:0] if_resp_data;
  logic             if_resp_err;

  logic             d_req_valid;
  logic             d_req_ready;
  logic [WIDTH-1:0] d_req_addr;
  logic [1:0]       d_req_size;
  logic             d_req_we;
  logic [WIDTH-1:0] d_req_wdata;
  logic             d_resp_valid;
  logic [WIDTH-1:0] d_resp_data;
  logic             d_resp_err;

  logic [WIDTH-1:0] mem_addr;
  logic [1:0]       mem_size;
  logic             mem_we;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  logic             busy;

  modport slave (
    input  if_req_valid, if_req_addr,
    input  d_req_valid, d_req_addr, d_req_size, d_req_we, d_req_wdata,
    input  mem_rdata,
    output if_req_ready, if_resp_valid, if_resp_data, if_resp_err,
    output d_req_ready, d_resp_valid, d_resp_data, d_resp_err,
    output mem_addr, mem_size, mem_we, mem_wdata,
    output busy
  );

  modport master (
    output if_req_valid, if_req_addr,
    output d_req_valid, d_req_addr, d_req_size, d_req_we, d_req_wdata,
    output mem_rdata,
    input  if_req_ready, if_resp_valid, if_resp_data, if_resp_err,
    input  d_req_ready, d_resp_valid, d_resp_data, d_resp_err,
    input  mem_addr, mem_size, mem_we, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Purpose : shares the single-ported unified memory between the fetch
//           requester and the load/store requester. One request is
//           accepted at a time, the memory is driven for exactly one
//           ACCESS cycle, and a one-cycle response pulse follows in RESP.
// Ports   : clk  - system clock, all state changes on the rising edge
//           rst  - synchronous active-high reset
//           bus  - mem_port_arbiter_if.slave (requests, responses,
//                  memory port, busy)
// Config  : define ARB_ROUND_ROBIN_EN to alternate winners on contention;
//           without it a data request always beats a fetch request.
module mem_port_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state;
  logic             lat_is_data;
  logic             lat_we;
  logic             lat_err;
  logic [1:0]       lat_size;
  logic [WIDTH-1:0] lat_addr;
  logic [WIDTH-1:0] lat_wdata;
  logic [WIDTH-1:0] resp_data;

  logic             in_access;
  logic             in_resp;
  logic             accept_window;
  logic             prefer_d;
  logic             grant_d;
  logic             grant_i;
  logic             d_resp_sel;
  logic             i_resp_sel;

  // Alignment/size legality of a request, evaluated at accept time.
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] addr_lo);
    return (size == 2'b11) ||
           (size == 2'b10 && addr_lo != 2'b00) ||
           (size == 2'b01 && addr_lo[0]);
  endfunction

`ifdef ARB_ROUND_ROBIN_EN
  // last_grant: 1 = data won last, 0 = fetch won last. On contention
  // the requester that did not win last time gets the port.
  logic last_grant;
  assign prefer_d = !last_grant;
`else
  assign prefer_d = 1'b1;
`endif

  assign in_access     = (state == ACCESS);
  assign in_resp       = (state == RESP);
  assign accept_window = !in_access && !rst;

  always_comb begin
    grant_d = accept_window && bus.d_req_valid && (!bus.if_req_valid || prefer_d);
    grant_i = accept_window && bus.if_req_valid && !grant_d;
  end

  assign bus.d_req_ready  = grant_d;
  assign bus.if_req_ready = grant_i;
  assign bus.busy         = (state != IDLE);

  // Memory port carries the latched request only during ACCESS; the write
  // enable is also masked by rst so a reset edge never commits a store.
  assign bus.mem_addr  = in_access ? lat_addr  : '0;
  assign bus.mem_size  = in_access ? lat_size  : 2'b10;
  assign bus.mem_wdata = in_access ? lat_wdata : '0;
  assign bus.mem_we    = in_access && lat_we && !lat_err && !rst;

  assign d_resp_sel        = in_resp && lat_is_data;
  assign i_resp_sel        = in_resp && !lat_is_data;
  assign bus.d_resp_valid  = d_resp_sel;
  assign bus.d_resp_data   = d_resp_sel ? resp_data : '0;
  assign bus.d_resp_err    = d_resp_sel && lat_err;
  assign bus.if_resp_valid = i_resp_sel;
  assign bus.if_resp_data  = i_resp_sel ? resp_data : '0;
  assign bus.if_resp_err   = i_resp_sel && lat_err;

  // Sequencer: accept in IDLE/RESP, one ACCESS cycle, one RESP cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lat_is_data <= 1'b0;
      lat_we      <= 1'b0;
      lat_err     <= 1'b0;
      lat_size    <= 2'b10;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      resp_data   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, RESP: begin
          if (grant_d) begin
            lat_is_data <= 1'b1;
            lat_addr    <= bus.d_req_addr;
            lat_size    <= bus.d_req_size;
            lat_we      <= bus.d_req_we;
            lat_wdata   <= bus.d_req_wdata;
            lat_err     <= access_err(bus.d_req_size, bus.d_req_addr[1:0]);
            state       <= ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant  <= 1'b1;
`endif
          end else if (grant_i) begin
            lat_is_data <= 1'b0;
            lat_addr    <= bus.if_req_addr;
            lat_size    <= 2'b10;
            lat_we      <= 1'b0;
            lat_wdata   <= '0;
            lat_err     <= access_err(2'b10, bus.if_req_addr[1:0]);
            state       <= ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant  <= 1'b0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          // Stores and rejected requests return zero data.
          resp_data <= (lat_we || lat_err) ? '0 : bus.mem_rdata;
          state     <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Purpose : drives mem_port_arbiter with directed and random requests and
//           compares every cycle against a transaction-level model (accept
//           timing, winner, response contents, memory port, busy). A word
//           array stands in for the unified memory.
// Build   : define ARB_ROUND_ROBIN_EN here as well as in the RTL to check
//           the alternating arbitration.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int WIDTH     = 32;
  localparam int MEM_WORDS = 256;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mem_port_arbiter #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] tb_mem  [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];

  int n_compared;
  int n_mismatched;

  // Model state: cycle counter, cycle of the most recent accept and the
  // transaction it started.
  int          cyc;
  int          last_accept;
  logic        last_grant_d;
  logic        pend_is_d;
  logic        pend_we;
  logic        pend_err;
  logic [1:0]  pend_size;
  logic [31:0] pend_addr;
  logic [31:0] pend_wdata;
  logic [31:0] pend_rdata;

  // Observations of the DUT used by the directed scenarios.
  int          n_we_cycles;
  int          n_d_resp;
  int          n_i_resp;
  int          n_d_ready;
  int          n_i_ready;
  logic [31:0] last_d_data;
  logic [31:0] last_i_data;
  logic        last_d_err;
  logic        last_i_err;
  int          i_resp_cyc [$];

  // Memory byte-lane semantics: right-aligned store data placed by size.
  function automatic logic [31:0] mergeStore(input logic [31:0] old, input logic [1:0] lo,
                                             input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    case (size)
      2'b00:   r[{lo, 3'b000} +: 8]     = wd[7:0];
      2'b01:   r[{lo[1], 4'b0000} +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  assign bus.mem_rdata = tb_mem[bus.mem_addr[9:2]];

  always @(posedge clk) begin
    if (bus.mem_we === 1'b1)
      tb_mem[bus.mem_addr[9:2]] <= mergeStore(tb_mem[bus.mem_addr[9:2]], bus.mem_addr[1:0],
                                              bus.mem_size, bus.mem_wdata);
  end

  // A request is illegal if its size code is 11 or the address is not a
  // multiple of the access size in bytes.
  function automatic logic expErr(input logic [1:0] size, input logic [31:0] addr);
    int unsigned bytes;
    if (size == 2'b11) return 1'b1;
    bytes = 32'd1 << size;
    return (int'(addr[1:0]) % bytes) != 0;
  endfunction

  function automatic logic [31:0] randAddr();
    int unsigned word;
    int unsigned off;
    word = $urandom_range(0, MEM_WORDS - 1);
    off  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 0;
    return 32'(word * 4 + off);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: inputs are already set. At the falling edge compare
  // all outputs against the model, then advance the model across the
  // rising edge. got_i/got_d report the model's winner for the driver.
  task automatic applyStimulus(output logic got_i, output logic got_d);
    int   phase;
    logic in_access, in_resp, exp_we, want_i, want_d, win_i, win_d;
    @(negedge clk);
    phase     = cyc - last_accept;
    in_access = (phase == 1);
    in_resp   = (phase == 2);
    exp_we    = in_access && pend_we && !pend_err && !rst;

    checkOutput("mem_we",    32'(bus.mem_we), 32'(exp_we));
    checkOutput("mem_addr",  bus.mem_addr, in_access ? pend_addr : 32'd0);
    checkOutput("mem_size",  32'(bus.mem_size), in_access ? 32'(pend_size) : 32'd2);
    checkOutput("mem_wdata", bus.mem_wdata, in_access ? pend_wdata : 32'd0);
    checkOutput("busy",      32'(bus.busy), 32'(in_access || in_resp));
    checkOutput("d_resp_valid",  32'(bus.d_resp_valid), 32'(in_resp && pend_is_d));
    checkOutput("d_resp_data",   bus.d_resp_data, (in_resp && pend_is_d) ? pend_rdata : 32'd0);
    checkOutput("d_resp_err",    32'(bus.d_resp_err), 32'(in_resp && pend_is_d && pend_err));
    checkOutput("if_resp_valid", 32'(bus.if_resp_valid), 32'(in_resp && !pend_is_d));
    checkOutput("if_resp_data",  bus.if_resp_data, (in_resp && !pend_is_d) ? pend_rdata : 32'd0);
    checkOutput("if_resp_err",   32'(bus.if_resp_err), 32'(in_resp && !pend_is_d && pend_err));

    want_d = !in_access && !rst && bus.d_req_valid;
    want_i = !in_access && !rst && bus.if_req_valid;
    if (want_d && want_i) begin
`ifdef ARB_ROUND_ROBIN_EN
      win_d = !last_grant_d;
`else
      win_d = 1'b1;
`endif
    end else begin
      win_d = want_d;
    end
    win_i = want_i && !win_d;
    checkOutput("d_req_ready",  32'(bus.d_req_ready),  32'(win_d));
    checkOutput("if_req_ready", 32'(bus.if_req_ready), 32'(win_i));

    if (bus.mem_we === 1'b1) n_we_cycles++;
    if (bus.d_req_ready === 1'b1) n_d_ready++;
    if (bus.if_req_ready === 1'b1) n_i_ready++;
    if (bus.d_resp_valid === 1'b1) begin
      n_d_resp++;
      last_d_data = bus.d_resp_data;
      last_d_err  = bus.d_resp_err;
    end
    if (bus.if_resp_valid === 1'b1) begin
      n_i_resp++;
      last_i_data = bus.if_resp_data;
      last_i_err  = bus.if_resp_err;
      i_resp_cyc.push_back(cyc);
    end

    if (in_access && !rst) begin
      pend_rdata = (pend_we || pend_err) ? 32'd0 : ref_mem[pend_addr[9:2]];
      if (exp_we)
        ref_mem[pend_addr[9:2]] = mergeStore(ref_mem[pend_addr[9:2]], pend_addr[1:0],
                                             pend_size, pend_wdata);
    end

    if (rst) begin
      last_accept  = -100;
      last_grant_d = 1'b0;
    end else if (win_d) begin
      pend_is_d    = 1'b1;
      pend_addr    = bus.d_req_addr;
      pend_size    = bus.d_req_size;
      pend_we      = bus.d_req_we;
      pend_wdata   = bus.d_req_wdata;
      pend_err     = expErr(bus.d_req_size, bus.d_req_addr);
      last_accept  = cyc;
      last_grant_d = 1'b1;
    end else if (win_i) begin
      pend_is_d    = 1'b0;
      pend_addr    = bus.if_req_addr;
      pend_size    = 2'b10;
      pend_we      = 1'b0;
      pend_wdata   = 32'd0;
      pend_err     = expErr(2'b10, bus.if_req_addr);
      last_accept  = cyc;
      last_grant_d = 1'b0;
    end
    got_i = win_i;
    got_d = win_d;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    logic gi, gd;
    repeat (n) applyStimulus(gi, gd);
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus.if_req_valid = 1'b0;
    bus.d_req_valid  = 1'b0;
    idleCycles(2);
    rst = 1'b0;
  endtask

  task automatic issueD(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata);
    logic gi, gd;
    int   k;
    bus.d_req_valid = 1'b1;
    bus.d_req_we    = we;
    bus.d_req_size  = size;
    bus.d_req_addr  = addr;
    bus.d_req_wdata = wdata;
    gd = 1'b0;
    k  = 0;
    while (!gd && k < 20) begin
      applyStimulus(gi, gd);
      k++;
    end
    bus.d_req_valid = 1'b0;
    if (!gd) checkOutput("d_accept_timeout", 32'(gd), 32'd1);
  endtask

  task automatic issueI(input logic [31:0] addr);
    logic gi, gd;
    int   k;
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = addr;
    gi = 1'b0;
    k  = 0;
    while (!gi && k < 20) begin
      applyStimulus(gi, gd);
      k++;
    end
    bus.if_req_valid = 1'b0;
    if (!gi) checkOutput("i_accept_timeout", 32'(gi), 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        gi, gd;
    logic [31:0] v;
    int          w0, r0, dr0, ir0;
    int          start;

    n_compared   = 0;
    n_mismatched = 0;
    cyc          = 0;
    last_accept  = -100;
    last_grant_d = 1'b0;
    pend_is_d = 1'b0; pend_we = 1'b0; pend_err = 1'b0; pend_size = 2'b10;
    pend_addr = '0; pend_wdata = '0; pend_rdata = '0;
    n_we_cycles = 0; n_d_resp = 0; n_i_resp = 0; n_d_ready = 0; n_i_ready = 0;
    last_d_data = '0; last_i_data = '0; last_d_err = 1'b0; last_i_err = 1'b0;

    rst              = 1'b1;
    bus.if_req_valid = 1'b0;
    bus.if_req_addr  = '0;
    bus.d_req_valid  = 1'b0;
    bus.d_req_addr   = '0;
    bus.d_req_size   = 2'b10;
    bus.d_req_we     = 1'b0;
    bus.d_req_wdata  = '0;

    for (int w = 0; w < MEM_WORDS; w++) begin
      v = $urandom();
      if (w == 'h40) v = 32'hDEADBEEF;
      if (w == 'hC0) v = 32'h55550300;
      tb_mem[w] <= v;
      ref_mem[w] = v;
    end

    $display("[TB] reset");
    doReset();
    checkOutput("reset_busy",     32'(bus.busy), 32'd0);
    checkOutput("reset_mem_size", 32'(bus.mem_size), 32'd2);
    checkOutput("reset_mem_we",   32'(bus.mem_we), 32'd0);
    checkOutput("reset_d_resp",   32'(bus.d_resp_valid), 32'd0);

    $display("[TB] single load");
    issueD(1'b0, 2'b10, 32'h100, 32'd0);
    idleCycles(3);
    checkOutput("load_data", last_d_data, 32'hDEADBEEF);
    checkOutput("load_err",  32'(last_d_err), 32'd0);

    $display("[TB] store then fetch back");
    w0 = n_we_cycles;
    issueD(1'b1, 2'b10, 32'h200, 32'h12345678);
    idleCycles(2);
    checkOutput("store_we_cycles", 32'(n_we_cycles - w0), 32'd1);
    checkOutput("store_mem", tb_mem['h80], 32'h12345678);
    issueI(32'h200);
    idleCycles(3);
    checkOutput("fetch_back_data", last_i_data, 32'h12345678);
    checkOutput("fetch_back_err",  32'(last_i_err), 32'd0);

    $display("[TB] misaligned and illegal");
    w0 = n_we_cycles;
    issueD(1'b0, 2'b01, 32'h101, 32'd0);
    idleCycles(3);
    checkOutput("half_mis_err",  32'(last_d_err), 32'd1);
    checkOutput("half_mis_data", last_d_data, 32'd0);
    issueD(1'b1, 2'b10, 32'h202, 32'hCAFEF00D);
    idleCycles(3);
    checkOutput("word_mis_err", 32'(last_d_err), 32'd1);
    checkOutput("word_mis_mem", tb_mem['h80], 32'h12345678);
    checkOutput("mis_we_cycles", 32'(n_we_cycles - w0), 32'd0);
    issueD(1'b0, 2'b11, 32'h0, 32'd0);
    idleCycles(3);
    checkOutput("size11_err", 32'(last_d_err), 32'd1);

    $display("[TB] simultaneous requests");
    doReset();
    dr0 = n_d_ready;
    ir0 = n_i_ready;
    bus.d_req_we     = 1'b0;
    bus.d_req_size   = 2'b10;
    bus.d_req_addr   = 32'h10;
    bus.if_req_addr  = 32'h20;
    bus.d_req_valid  = 1'b1;
    bus.if_req_valid = 1'b1;
    idleCycles(12);
    bus.d_req_valid  = 1'b0;
    bus.if_req_valid = 1'b0;
    idleCycles(3);
`ifdef ARB_ROUND_ROBIN_EN
    checkOutput("contend_d_grants", 32'(n_d_ready - dr0), 32'd3);
    checkOutput("contend_i_grants", 32'(n_i_ready - ir0), 32'd3);
`else
    checkOutput("contend_d_grants", 32'(n_d_ready - dr0), 32'd6);
    checkOutput("contend_i_grants", 32'(n_i_ready - ir0), 32'd0);
`endif

    $display("[TB] reset during store");
    w0 = n_we_cycles;
    r0 = n_d_resp;
    bus.d_req_we    = 1'b1;
    bus.d_req_size  = 2'b10;
    bus.d_req_addr  = 32'h300;
    bus.d_req_wdata = 32'hAAAAAAAA;
    bus.d_req_valid = 1'b1;
    applyStimulus(gi, gd);
    bus.d_req_valid = 1'b0;
    rst = 1'b1;
    applyStimulus(gi, gd);
    rst = 1'b0;
    checkOutput("rst_mid_busy",     32'(bus.busy), 32'd0);
    checkOutput("rst_mid_mem_size", 32'(bus.mem_size), 32'd2);
    checkOutput("rst_mid_mem_addr", bus.mem_addr, 32'd0);
    idleCycles(3);
    checkOutput("rst_mid_mem", tb_mem['hC0], 32'h55550300);
    checkOutput("rst_mid_we",  32'(n_we_cycles - w0), 32'd0);
    checkOutput("rst_mid_resp", 32'(n_d_resp - r0), 32'd0);

    $display("[TB] back-to-back fetches");
    i_resp_cyc.delete();
    start = cyc;
    bus.if_req_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      int k;
      bus.if_req_addr = 32'(j * 4);
      gi = 1'b0;
      k  = 0;
      while (!gi && k < 20) begin
        applyStimulus(gi, gd);
        k++;
      end
      if (!gi) checkOutput("b2b_accept_timeout", 32'(gi), 32'd1);
    end
    bus.if_req_valid = 1'b0;
    idleCycles(3);
    checkOutput("b2b_count", 32'(i_resp_cyc.size()), 32'd3);
    if (i_resp_cyc.size() == 3) begin
      for (int j = 0; j < 3; j++)
        checkOutput("b2b_resp_cycle", 32'(i_resp_cyc[j] - start), 32'(2 + 2 * j));
    end

    $display("[TB] random traffic");
    for (int c = 0; c < 800; c++) begin
      applyStimulus(gi, gd);
      if (gi || !bus.if_req_valid) begin
        bus.if_req_valid = ($urandom_range(0, 2) != 0);
        bus.if_req_addr  = randAddr();
      end
      if (gd || !bus.d_req_valid) begin
        bus.d_req_valid = ($urandom_range(0, 2) != 0);
        bus.d_req_addr  = randAddr();
        bus.d_req_size  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        bus.d_req_we    = 1'($urandom_range(0, 1));
        bus.d_req_wdata = $urandom();
      end
    end
    bus.if_req_valid = 1'b0;
    bus.d_req_valid  = 1'b0;
    idleCycles(4);
    for (int w = 0; w < MEM_WORDS; w++)
      checkOutput("final_mem_word", tb_mem[w], ref_mem[w]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
